// File: rtl/eBike_pkg.sv
// rtl/eBike_pkg.sv - shared widths, states and limits for the incline integrator
package eBike_pkg;

   localparam int INCL_W     = 13;
   localparam int ROLL_INT_W = 27;
   localparam int RATE_W     = 16;

   localparam logic signed [ROLL_INT_W-1:0] ROLL_INT_MAX = 27'sh3FF_FFFF;
   localparam logic signed [ROLL_INT_W-1:0] ROLL_INT_MIN = 27'sh400_0000;

   typedef enum logic {CAL, RUN} integ_state_t;

endpackage

// File: rtl/inertial_integrator_sat_accum.sv
// rtl/inertial_integrator_sat_accum.sv - signed accumulate with clamp to the W-bit range
module sat_accum #(
   parameter int W     = 27,
   parameter int ADD_W = 19
) (
   input  logic signed [W-1:0]     acc,
   input  logic signed [ADD_W-1:0] addend,
   output logic signed [W-1:0]     sum
);

   // One guard bit beyond the wider operand makes the raw sum exact.
   localparam int SW = ((W > ADD_W) ? W : ADD_W) + 1;
   localparam logic signed [SW-1:0] ONE   = {{(SW-1){1'b0}}, 1'b1};
   localparam logic signed [SW-1:0] MAX_V = (ONE <<< (W-1)) - ONE;
   localparam logic signed [SW-1:0] MIN_V = -(ONE <<< (W-1));

   logic signed [SW-1:0] wide;

   // Exact sum, then clamp so the accumulator never wraps.
   always_comb begin
      wide = SW'(acc) + SW'(addend);
      if (wide > MAX_V)
         sum = MAX_V[W-1:0];
      else if (wide < MIN_V)
         sum = MIN_V[W-1:0];
      else
         sum = wide[W-1:0];
   end

endmodule

// File: rtl/inertial_integrator.sv
// rtl/inertial_integrator.sv - gyro offset calibration, rate integration and accel fusion
module inertial_integrator
   import eBike_pkg::*;
#(
   parameter int CAL_LOG2    = 4,
   parameter int FUSION_GAIN = 1024,
   parameter int AY_SCALE    = 327
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     vld,
   input  logic signed [RATE_W-1:0] roll_rt,
   input  logic signed [RATE_W-1:0] AY,
   input  logic                     recal,
   output logic signed [INCL_W-1:0] incline,
   output logic                     incline_vld,
   output logic                     cal_done
);

   localparam int SUM_W = RATE_W + CAL_LOG2;
   localparam int ADD_W = RATE_W + 3;
   localparam logic signed [ADD_W-1:0] GAIN = ADD_W'(FUSION_GAIN);

   integ_state_t                  state, state_nxt;
   logic [CAL_LOG2-1:0]           cal_cnt;
   logic signed [SUM_W-1:0]       cal_sum, cal_sum_nxt;
   logic                          cal_last;
   logic signed [RATE_W-1:0]      offset;
   logic signed [ROLL_INT_W-1:0]  roll_int, roll_int_nxt;
   logic signed [RATE_W:0]        roll_comp;
   logic signed [24:0]            ay_prod;
   logic signed [INCL_W-1:0]      incl_acc;
   logic signed [ADD_W-1:0]       fusion, addend;

   // Per-sample arithmetic: calibration sum, offset-corrected rate and fusion nudge.
   always_comb begin
      cal_sum_nxt = cal_sum + SUM_W'(roll_rt);
      cal_last    = (cal_cnt == {CAL_LOG2{1'b1}});
      roll_comp   = (RATE_W+1)'(roll_rt) - (RATE_W+1)'(offset);
      ay_prod     = 25'(AY) * 25'(AY_SCALE);
      incl_acc    = INCL_W'(ay_prod >>> 12);
      fusion      = '0;
      if (incl_acc > incline)
         fusion = GAIN;
      else if (incl_acc < incline)
         fusion = -GAIN;
      // Gyro sign convention: positive rate lowers the incline.
      addend      = fusion - ADD_W'(roll_comp);
   end

   sat_accum #(.W(ROLL_INT_W), .ADD_W(ADD_W)) u_sat_accum (
      .acc    (roll_int),
      .addend (addend),
      .sum    (roll_int_nxt)
   );

   // Leave CAL on the last calibration sample; recal always returns to CAL.
   always_comb begin
      state_nxt = state;
      if (recal)
         state_nxt = CAL;
      else if (state == CAL && vld && cal_last)
         state_nxt = RUN;
   end

   // State register and its registered RUN flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= CAL;
         cal_done <= 1'b0;
      end else begin
         state    <= state_nxt;
         cal_done <= (state_nxt == RUN);
      end
   end

   // Calibration accumulation, offset capture and integrator update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cal_cnt     <= '0;
         cal_sum     <= '0;
         offset      <= '0;
         roll_int    <= '0;
         incline_vld <= 1'b0;
      end else if (recal) begin
         cal_cnt     <= '0;
         cal_sum     <= '0;
         offset      <= '0;
         roll_int    <= '0;
         incline_vld <= 1'b0;
      end else begin
         incline_vld <= 1'b0;
         if (vld) begin
            if (state == CAL) begin
               cal_cnt <= cal_cnt + 1'b1;
               if (cal_last) begin
                  offset   <= RATE_W'(cal_sum_nxt >>> CAL_LOG2);
                  cal_sum  <= '0;
                  roll_int <= '0;
               end else begin
                  cal_sum  <= cal_sum_nxt;
               end
            end else begin
               roll_int    <= roll_int_nxt;
               incline_vld <= 1'b1;
            end
         end
      end
   end

   assign incline = roll_int[ROLL_INT_W-1 -: INCL_W];

endmodule

// File: tb/tb_inertial_integrator.sv
// tb/tb_inertial_integrator.sv - directed and random checks against a reference model
module tb_inertial_integrator;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               vld;
   logic               recal;
   logic signed [15:0] roll_rt;
   logic signed [15:0] ay;
   logic signed [12:0] incline;
   logic               incline_vld;
   logic               cal_done;

   int n_cmp = 0;
   int n_bad = 0;

   bit     m_run;
   int     m_cnt;
   longint m_sum;
   longint m_off;
   longint m_int;
   bit     m_ivld;

   always #5 clk = ~clk;

   inertial_integrator dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .vld         (vld),
      .roll_rt     (roll_rt),
      .AY          (ay),
      .recal       (recal),
      .incline     (incline),
      .incline_vld (incline_vld),
      .cal_done    (cal_done)
   );

   task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_run  = 0;
      m_cnt  = 0;
      m_sum  = 0;
      m_off  = 0;
      m_int  = 0;
      m_ivld = 0;
   endtask

   task automatic model_edge(input bit v, input int r, input int a, input bit rc);
      longint acc, cur, fus;
      m_ivld = 0;
      if (rc) begin
         model_reset();
      end else if (v) begin
         if (!m_run) begin
            m_sum += r;
            m_cnt++;
            if (m_cnt == 16) begin
               m_off = m_sum >>> 4;
               m_int = 0;
               m_run = 1;
            end
         end else begin
            acc = (longint'(a) * 327) >>> 12;
            cur = m_int >>> 14;
            fus = (acc > cur) ? 1024 : ((acc < cur) ? -1024 : 0);
            m_int = m_int - (r - m_off) + fus;
            if (m_int > (64'sd1 <<< 26) - 1) m_int = (64'sd1 <<< 26) - 1;
            if (m_int < -(64'sd1 <<< 26))    m_int = -(64'sd1 <<< 26);
            m_ivld = 1;
         end
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, "_incline"}, incline, m_int >>> 14);
      check({tag, "_incline_vld"}, {63'd0, incline_vld}, {63'd0, m_ivld});
      check({tag, "_cal_done"}, {63'd0, cal_done}, {63'd0, m_run});
   endtask

   task automatic step(input string tag, input bit v, input int r, input int a, input bit rc);
      @(negedge clk);
      vld     = v;
      roll_rt = 16'(r);
      ay      = 16'(a);
      recal   = rc;
      @(posedge clk);
      #1;
      model_edge(v, r, a, rc);
      check_all(tag);
   endtask

   initial begin
      rst_n   = 1'b0;
      vld     = 1'b0;
      recal   = 1'b0;
      roll_rt = '0;
      ay      = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Calibration with constant rate 16, idle gaps interleaved.
      for (int i = 0; i < 16; i++) begin
         step("cal", 1'b1, 16, 0, 1'b0);
         if (i % 5 == 2) step("cal_idle", 1'b0, 999, 999, 1'b0);
      end
      check("cal_done_rise", {63'd0, cal_done}, 64'sd1);

      // Steady drift with offset 16.
      for (int i = 0; i < 32; i++) step("drift", 1'b1, 1016, 0, 1'b0);
      step("drift_idle", 1'b0, 0, 0, 1'b0);

      // Positive saturation: incline must pin at the top, never wrap.
      for (int i = 0; i < 2200; i++) step("sat", 1'b1, -32768, 0, 1'b0);
      check("sat_top", incline, 64'sd4095);

      // Recalibrate to offset 0 and let fusion pull toward incl_acc=79.
      step("recal0", 1'b0, 0, 0, 1'b1);
      check("recal0_zero", incline, 64'sd0);
      for (int i = 0; i < 16; i++) step("cal0", 1'b1, 0, 0, 1'b0);
      for (int i = 0; i < 1400; i++) begin
         step("fusion", 1'b1, 0, 1000, 1'b0);
         if (i == 15) check("fusion_first", incline, 64'sd1);
      end
      check("fusion_dither", {63'd0, (incline == 13'sd78 || incline == 13'sd79)}, 64'sd1);

      // recal together with vld wins; sample is discarded.
      step("recal_vld", 1'b1, 500, 1000, 1'b1);
      check("recal_vld_incl", incline, 64'sd0);
      check("recal_vld_done", {63'd0, cal_done}, 64'sd0);
      for (int i = 0; i < 16; i++) step("cal1", 1'b1, int'($urandom_range(0, 400)) - 200, 0, 1'b0);
      for (int i = 0; i < 20; i++) step("run1", 1'b1, int'($urandom_range(0, 400)) - 200, 0, 1'b0);

      // Async reset between edges, mid-calibration.
      step("recal2", 1'b0, 0, 0, 1'b1);
      for (int i = 0; i < 7; i++) step("cal2", 1'b1, 40, 0, 1'b0);
      @(negedge clk);
      vld = 1'b0;
      recal = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 15; i++) step("cal3", 1'b1, -24, 0, 1'b0);
      check("cal3_not_done", {63'd0, cal_done}, 64'sd0);
      step("cal3_last", 1'b1, -24, 0, 1'b0);
      check("cal3_done", {63'd0, cal_done}, 64'sd1);

      // Random traffic with occasional recalibration.
      for (int i = 0; i < 800; i++) begin
         step("rand",
              $urandom_range(0, 3) != 0,
              int'($urandom_range(0, 65535)) - 32768,
              int'($urandom_range(0, 65535)) - 32768,
              $urandom_range(0, 149) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
